// File: rtl/dcntr_wrap_mon.sv
// Downstream monitor for a WIDTH-bit down counter: checks each sampled step, counts wraps,
// latches sticky errors. Optional stall detection is built when DCNT_STALL_CHECK_EN is defined.
module dcntr_wrap_mon #(
  parameter int WIDTH    = 4,
  parameter int WRAPW    = 8,
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  input  logic             clr_in,
  output logic             wrap_pulse,
  output logic [WRAPW-1:0] wrap_cnt,
  output logic             step_err,
  output logic             stall,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_TRACK = 2'b01,
    S_FAULT = 2'b10
  } state_t;

  localparam logic [WRAPW-1:0] WRAP_SAT = '1;

  // A hold threshold below one would flag a stall before any hold was seen.
  if (HOLD_MAX < 1) begin : g_hold_max_check
    $error("dcntr_wrap_mon: HOLD_MAX must be at least 1");
  end

  state_t           state_q;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] exp_val;
  logic             is_step;
  logic             is_hold;
  logic             tracking;

  // NOTE: every signal driven from always_comb gets a default first, so no latch is inferred.
  always_comb begin
    exp_val  = prev - 1'b1;
    is_step  = (cnt_in == exp_val);
    is_hold  = (cnt_in == prev);
    tracking = cnt_valid && (state_q == S_TRACK);
  end

  assign state = state_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_INIT;
      prev       <= '0;
      wrap_cnt   <= '0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
    end else if (clr_in) begin
      // prev is kept across a clear; the sample in this cycle is dropped.
      state_q    <= S_INIT;
      wrap_cnt   <= '0;
      wrap_pulse <= 1'b0;
      step_err   <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (cnt_valid) begin
        prev <= cnt_in;
        unique case (state_q)
          S_INIT: state_q <= S_TRACK;
          S_TRACK: begin
            if (is_step) begin
              if (prev == '0) begin
                wrap_pulse <= 1'b1;
                if (wrap_cnt != WRAP_SAT) wrap_cnt <= wrap_cnt + 1'b1;
              end
            end else if (!is_hold) begin
              step_err <= 1'b1;
              state_q  <= S_FAULT;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DCNT_STALL_CHECK_EN
  localparam int HOLDW = $clog2(HOLD_MAX + 1);
  localparam logic [HOLDW-1:0] HOLD_SAT  = HOLDW'(HOLD_MAX);
  localparam logic [HOLDW-1:0] HOLD_LAST = HOLDW'(HOLD_MAX - 1);

  logic [HOLDW-1:0] hold_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr_in) begin
      hold_cnt <= '0;
      stall    <= 1'b0;
    end else if (tracking) begin
      if (is_step) begin
        hold_cnt <= '0;
      end else if (is_hold) begin
        // The count saturates so a long stall cannot roll over.
        if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) stall <= 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  logic unused_track;
  assign unused_track = tracking;
  assign stall        = 1'b0;
`endif

endmodule

// File: tb/tb_dcntr_wrap_mon.sv
// Self-checking bench for dcntr_wrap_mon: a behavioural model pushes expected outputs
// into a scoreboard queue each cycle; the queue is popped and compared after the edge.
module tb_dcntr_wrap_mon;

  localparam int WIDTH    = 4;
  localparam int WRAPW    = 8;
  localparam int HOLD_MAX = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_valid;
  logic             clr_in;
  logic             wrap_pulse;
  logic [WRAPW-1:0] wrap_cnt;
  logic             step_err;
  logic             stall;
  logic [1:0]       state;

  dcntr_wrap_mon #(.WIDTH(WIDTH), .WRAPW(WRAPW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .cnt_valid(cnt_valid), .clr_in(clr_in),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .step_err(step_err), .stall(stall),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pulse;
    logic [7:0] wcnt;
    logic       err;
    logic       stl;
    logic [1:0] st;
  } obs_t;

  obs_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

`ifdef DCNT_STALL_CHECK_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // Reference model state.
  int   m_st;      // 0 INIT, 1 TRACK, 2 FAULT
  int   m_prev;
  int   m_wcnt;
  int   m_hold;
  bit   m_pulse, m_err, m_stall;

  task automatic model_update(input bit v, input int c, input bit clr, input bit rst);
    if (rst) begin
      m_st = 0; m_prev = 0; m_wcnt = 0; m_hold = 0;
      m_pulse = 0; m_err = 0; m_stall = 0;
    end else if (clr) begin
      m_st = 0; m_wcnt = 0; m_hold = 0;
      m_pulse = 0; m_err = 0; m_stall = 0;
    end else begin
      m_pulse = 0;
      if (v) begin
        if (m_st == 0) begin
          m_st = 1;
        end else if (m_st == 1) begin
          if (c == ((m_prev + 15) % 16)) begin
            m_hold = 0;
            if (m_prev == 0) begin
              m_pulse = 1;
              if (m_wcnt < 255) m_wcnt = m_wcnt + 1;
            end
          end else if (c == m_prev) begin
            if (STALL_EN) begin
              m_hold = m_hold + 1;
              if (m_hold >= HOLD_MAX) m_stall = 1;
            end
          end else begin
            m_err = 1;
            m_st  = 2;
          end
        end
        m_prev = c;
      end
    end
  endtask

  // One clock of stimulus; the model prediction is queued, then checked after the edge.
  task automatic cycle(input bit v, input int c, input bit clr, input bit rst);
    obs_t e, o;
    reset     = rst;
    clr_in    = clr;
    cnt_valid = v;
    cnt_in    = 4'(c);
    model_update(v, c, clr, rst);
    e.pulse = m_pulse; e.wcnt = 8'(m_wcnt); e.err = m_err; e.stl = m_stall; e.st = 2'(m_st);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    o = {wrap_pulse, wrap_cnt, step_err, stall, state};
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL scoreboard t=%0t: got pulse=%0b wcnt=%0d err=%0b stall=%0b state=%0d, want pulse=%0b wcnt=%0d err=%0b stall=%0b state=%0d",
               $time, o.pulse, o.wcnt, o.err, o.stl, o.st, e.pulse, e.wcnt, e.err, e.stl, e.st);
    end
    reset = 1'b0; clr_in = 1'b0; cnt_valid = 1'b0;
  endtask

  task automatic sample(input int c);
    cycle(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    cycle(1'b0, 0, 1'b0, 1'b1);
    tests_run++;
    if ({wrap_pulse, wrap_cnt, step_err, stall, state} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got pulse=%0b wcnt=%0d err=%0b stall=%0b state=%0d, want all 0",
               wrap_pulse, wrap_cnt, step_err, stall, state);
    end
  endtask

  task automatic test_wrap_basic;
    cycle(1'b0, 0, 1'b0, 1'b1);
    sample(3);
    tests_run++;
    if (state !== 2'b01) begin
      tests_failed++;
      $display("FAIL first_sample_track: got state=%0d want 1", state);
    end
    sample(2); sample(1); sample(0);
    sample(15);
    tests_run++;
    if (wrap_pulse !== 1'b1 || wrap_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL wrap_after_F: got pulse=%0b wcnt=%0d want pulse=1 wcnt=1", wrap_pulse, wrap_cnt);
    end
    sample(14);
    tests_run++;
    if (wrap_pulse !== 1'b0 || step_err !== 1'b0 || wrap_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL pulse_one_cycle: got pulse=%0b err=%0b wcnt=%0d want 0 0 1", wrap_pulse, step_err, wrap_cnt);
    end
  endtask

  task automatic test_saturate;
    cycle(1'b0, 0, 1'b0, 1'b1);
    sample(15);
    for (int w = 1; w <= 256; w++) begin
      for (int v = 14; v >= 0; v--) sample(v);
      sample(15);
      if (w == 255) begin
        tests_run++;
        if (wrap_cnt !== 8'd255) begin
          tests_failed++;
          $display("FAIL wrap_255: got wcnt=%0d want 255", wrap_cnt);
        end
      end
    end
    tests_run++;
    if (wrap_pulse !== 1'b1 || wrap_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL wrap_256_saturated: got pulse=%0b wcnt=%0d want pulse=1 wcnt=255", wrap_pulse, wrap_cnt);
    end
  endtask

  task automatic test_fault;
    cycle(1'b0, 0, 1'b1, 1'b0);
    sample(1); sample(0);
    for (int v = 15; v >= 7; v--) sample(v);
    sample(6); sample(5); sample(2);
    tests_run++;
    if (step_err !== 1'b1 || state !== 2'b10 || wrap_cnt !== 8'd1) begin
      tests_failed++;
      $display("FAIL illegal_step: got err=%0b state=%0d wcnt=%0d want err=1 state=2 wcnt=1", step_err, state, wrap_cnt);
    end
    sample(1); sample(0); sample(15);
    tests_run++;
    if (wrap_pulse !== 1'b0 || wrap_cnt !== 8'd1 || state !== 2'b10) begin
      tests_failed++;
      $display("FAIL fault_no_wrap: got pulse=%0b wcnt=%0d state=%0d want 0 1 2", wrap_pulse, wrap_cnt, state);
    end
    cycle(1'b0, 0, 1'b1, 1'b0);
    tests_run++;
    if (state !== 2'b00 || wrap_cnt !== 8'd0 || step_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL clr_from_fault: got state=%0d wcnt=%0d err=%0b want all 0", state, wrap_cnt, step_err);
    end
  endtask

  task automatic test_clr_same_cycle;
    cycle(1'b1, 9, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    tests_run++;
    if (state !== 2'b00) begin
      tests_failed++;
      $display("FAIL clr_drops_sample: got state=%0d want 0", state);
    end
    sample(4);
    tests_run++;
    if (state !== 2'b01 || step_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL track_after_clr: got state=%0d err=%0b want state=1 err=0", state, step_err);
    end
    sample(3);
  endtask

  task automatic test_stall;
`ifdef DCNT_STALL_CHECK_EN
    cycle(1'b0, 0, 1'b0, 1'b1);
    sample(6);
    for (int i = 1; i <= 15; i++) begin
      sample(6);
      if (i == 14) begin
        tests_run++;
        if (stall !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_early: got stall=%0b want 0 after 14 holds", stall);
        end
      end
    end
    tests_run++;
    if (stall !== 1'b1 || state !== 2'b01) begin
      tests_failed++;
      $display("FAIL stall_at_max: got stall=%0b state=%0d want stall=1 state=1", stall, state);
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    sample(6);
    for (int i = 0; i < 14; i++) sample(6);
    sample(5);
    sample(5);
    tests_run++;
    if (stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_cleared_by_step: got stall=%0b want 0", stall);
    end
`else
    cycle(1'b0, 0, 1'b0, 1'b1);
    sample(6);
    for (int i = 0; i < 100; i++) sample(6);
    tests_run++;
    if (stall !== 1'b0 || state !== 2'b01) begin
      tests_failed++;
      $display("FAIL no_stall_disabled: got stall=%0b state=%0d want stall=0 state=1", stall, state);
    end
`endif
  endtask

  task automatic test_reset_from_fault;
    cycle(1'b0, 0, 1'b0, 1'b1);
    sample(0);
    for (int w = 0; w < 3; w++)
      for (int v = 15; v >= 0; v--) sample(v);
    sample(5);
    tests_run++;
    if (state !== 2'b10 || wrap_cnt !== 8'd3 || step_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_wcnt3: got state=%0d wcnt=%0d err=%0b want 2 3 1", state, wrap_cnt, step_err);
    end
    cycle(1'b0, 0, 1'b0, 1'b1);
    tests_run++;
    if ({wrap_pulse, wrap_cnt, step_err, stall, state} !== 13'd0) begin
      tests_failed++;
      $display("FAIL reset_from_fault: got pulse=%0b wcnt=%0d err=%0b stall=%0b state=%0d want all 0",
               wrap_pulse, wrap_cnt, step_err, stall, state);
    end
  endtask

  initial begin
    reset = 1'b1; clr_in = 1'b0; cnt_valid = 1'b0; cnt_in = '0;
    m_st = 0; m_prev = 0; m_wcnt = 0; m_hold = 0; m_pulse = 0; m_err = 0; m_stall = 0;
    @(posedge clk);
    #1;
    test_reset;
    test_wrap_basic;
    test_saturate;
    test_fault;
    test_clr_same_cycle;
    test_stall;
    test_reset_from_fault;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
